mdio_slave_responder: RTL and testbench

- PHY-side responder for the MDIO/SMI management interface: the far end of our SMI master.
- Oversamples MDC/MDIO on the system clock and decodes Clause-22 frames (preamble, ST, OP, PHYAD, REGAD, TA, DATA).
- Issues writes and reads on a simple local register port.
- Drives MDIO only during the read turnaround and read data phases.
- Used as the management front end of FPGA-side PHY-emulation register files and as the bench responder for the SMI master.

---
 rtl/mdio_slave_responder.sv | 199 +++++++++++++++++++
 tb/tb_mdio_slave_responder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_slave_responder.sv
// mdio_slave_responder: Clause-22 MDIO responder that oversamples MDC/MDIO on clk
// and turns addressed frames into single-cycle strobes on a local register port.
module mdio_slave_responder #(
  parameter logic [4:0] PHY_ADDR = 5'd1,
  parameter int         PRE_MIN  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdc,
  inout  wire         mdio,
  output logic [4:0]  reg_addr,
  output logic        reg_wr_en,
  output logic [15:0] reg_wr_data,
  output logic        reg_rd_req,
  input  logic [15:0] reg_rd_data,
  output logic        frame_done,
  output logic        frame_err
);
  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_ST2   = 4'd1;
  localparam logic [3:0] S_OP    = 4'd2;
  localparam logic [3:0] S_PHYAD = 4'd3;
  localparam logic [3:0] S_REGAD = 4'd4;
  localparam logic [3:0] S_TA    = 4'd5;
  localparam logic [3:0] S_WDATA = 4'd6;
  localparam logic [3:0] S_RDATA = 4'd7;
  localparam logic [3:0] S_SKIP  = 4'd8;
  localparam logic [5:0] PRE_REQ = 6'(PRE_MIN);

  logic [1:0]  r_mdc_s;
  logic [1:0]  r_mdio_s;
  logic        r_mdc_prev;
  logic [3:0]  r_state;
  logic [4:0]  r_bit_cnt;
  logic [5:0]  r_pre_cnt;
  logic        r_op_hi;
  logic        r_is_rd;
  logic [4:0]  r_phyad;
  logic [3:0]  r_regad;
  logic [15:0] r_shift;
  logic        r_mdio_oe;
  logic        r_mdio_out;
  logic [4:0]  r_reg_addr;
  logic [15:0] r_wr_data;
  logic        r_wr_en;
  logic        r_rd_req;
  logic        r_rd_latch;
  logic        r_done;
  logic        r_err;

  logic        w_rise;
  logic        w_fall;
  logic        w_bit;
  logic [4:0]  w_cnt_nx;
  logic [1:0]  w_op;
  logic [4:0]  w_regad;
  logic [15:0] w_wdata;

  assign w_rise   = r_mdc_s[1] & ~r_mdc_prev;
  assign w_fall   = ~r_mdc_s[1] & r_mdc_prev;
  assign w_bit    = r_mdio_s[1];
  assign w_cnt_nx = r_bit_cnt + 5'd1;
  assign w_op     = {r_op_hi, w_bit};
  assign w_regad  = {r_regad, w_bit};
  assign w_wdata  = {r_shift[14:0], w_bit};

  assign mdio        = r_mdio_oe ? r_mdio_out : 1'bz;
  assign reg_addr    = r_reg_addr;
  assign reg_wr_en   = r_wr_en;
  assign reg_wr_data = r_wr_data;
  assign reg_rd_req  = r_rd_req;
  assign frame_done  = r_done;
  assign frame_err   = r_err;

  // Synchronisers run through reset so no false MDC edge appears when it lifts.
  always_ff @(posedge clk) begin
    r_mdc_s    <= {r_mdc_s[0], mdc};
    r_mdio_s   <= {r_mdio_s[0], mdio};
    r_mdc_prev <= r_mdc_s[1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_pre_cnt  <= '0;
      r_op_hi    <= 1'b0;
      r_is_rd    <= 1'b0;
      r_phyad    <= '0;
      r_regad    <= '0;
      r_shift    <= '0;
      r_mdio_oe  <= 1'b0;
      r_mdio_out <= 1'b1;
      r_reg_addr <= '0;
      r_wr_data  <= '0;
      r_wr_en    <= 1'b0;
      r_rd_req   <= 1'b0;
      r_rd_latch <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_wr_en    <= 1'b0;
      r_rd_req   <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rd_latch <= r_rd_req;
      if (r_rd_latch) r_shift <= reg_rd_data;
      case (r_state)
        S_IDLE: if (w_rise) begin
          if (w_bit) r_pre_cnt <= (r_pre_cnt == 6'd32) ? r_pre_cnt : r_pre_cnt + 6'd1;
          else if (r_pre_cnt >= PRE_REQ) begin
            r_state   <= S_ST2;
            r_bit_cnt <= '0;
            r_pre_cnt <= '0;
          end else r_pre_cnt <= '0;
        end
        S_ST2: if (w_rise) begin
          r_state   <= w_bit ? S_OP : S_IDLE;
          r_err     <= ~w_bit;
          r_bit_cnt <= '0;
        end
        S_OP: if (w_rise) begin
          r_op_hi   <= w_bit;
          r_bit_cnt <= w_cnt_nx;
          if (r_bit_cnt == 5'd1) begin
            r_bit_cnt <= '0;
            r_is_rd   <= w_op[1];
            r_state   <= ^w_op ? S_PHYAD : S_IDLE;
            r_err     <= ~^w_op;
          end
        end
        S_PHYAD: if (w_rise) begin
          r_phyad   <= {r_phyad[3:0], w_bit};
          r_bit_cnt <= w_cnt_nx;
          if (r_bit_cnt == 5'd4) begin
            r_state   <= S_REGAD;
            r_bit_cnt <= '0;
          end
        end
        S_REGAD: if (w_rise) begin
          r_regad   <= w_regad[3:0];
          r_bit_cnt <= w_cnt_nx;
          if (r_bit_cnt == 5'd4) begin
            r_bit_cnt <= '0;
            if (r_phyad != PHY_ADDR) r_state <= S_SKIP;
            else begin
              r_state    <= S_TA;
              r_reg_addr <= w_regad;
              r_rd_req   <= r_is_rd;
            end
          end
        end
        S_TA: if (w_rise) begin
          r_bit_cnt <= w_cnt_nx;
          if (r_bit_cnt == 5'd1) begin
            r_state   <= r_is_rd ? S_RDATA : S_WDATA;
            r_bit_cnt <= '0;
          end
        end else if (w_fall && r_is_rd && r_bit_cnt == 5'd1) begin
          r_mdio_oe  <= 1'b1;
          r_mdio_out <= 1'b0;
        end
        S_WDATA: if (w_rise) begin
          r_shift   <= w_wdata;
          r_bit_cnt <= w_cnt_nx;
          if (r_bit_cnt == 5'd15) begin
            r_wr_data <= w_wdata;
            r_wr_en   <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
          end
        end
        // Data changes on MDC fall; the fall after the 16th rise hands the line back.
        S_RDATA: if (w_rise) r_bit_cnt <= w_cnt_nx;
        else if (w_fall) begin
          if (r_bit_cnt == 5'd16) begin
            r_mdio_oe  <= 1'b0;
            r_mdio_out <= 1'b1;
            r_done     <= 1'b1;
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
          end else begin
            r_mdio_out <= r_shift[15];
            r_shift    <= {r_shift[14:0], 1'b0};
          end
        end
        S_SKIP: if (w_rise) begin
          r_bit_cnt <= w_cnt_nx;
          if (r_bit_cnt == 5'd17) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdio_slave_responder.sv
// tb_mdio_slave_responder: behavioural MDIO master plus register file, checked against
// a frame-level model of which frames are served, rejected or ignored.
module tb_mdio_slave_responder;
  localparam logic [4:0] PHY = 5'd1;
  localparam int         PRE = 32;

  typedef struct packed {
    int          wr;
    int          rd;
    int          done;
    int          err;
    logic        oe;
    logic        post_oe;
    logic        ta_val;
    logic [17:0] oe_seq;
    logic [15:0] rdata;
    logic [15:0] wd;
    logic [4:0]  addr;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mdc = 1'b0;
  wire         mdio;
  logic        m_oe = 1'b1;
  logic        m_out = 1'b1;
  logic [4:0]  reg_addr;
  logic        reg_wr_en;
  logic [15:0] reg_wr_data;
  logic        reg_rd_req;
  logic [15:0] reg_rd_data = '0;
  logic        frame_done;
  logic        frame_err;

  int hp = 5;
  int checks = 0;
  int errors = 0;
  int n_wr = 0, n_rd = 0, n_done = 0, n_err = 0, n_both = 0, n_oe = 0;
  logic [15:0] rf [32];
  logic [15:0] cap_wd = '0;
  logic [15:0] exp_mem [32];
  logic [4:0]  exp_addr = '0;

  assign mdio = m_oe ? m_out : 1'bz;
  always #5 clk = ~clk;

  mdio_slave_responder #(.PHY_ADDR(PHY), .PRE_MIN(PRE)) dut (
    .clk(clk), .rst_n(rst_n), .mdc(mdc), .mdio(mdio),
    .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
    .reg_rd_req(reg_rd_req), .reg_rd_data(reg_rd_data),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always @(posedge clk) begin
    if (reg_wr_en) begin
      n_wr <= n_wr + 1;
      cap_wd <= reg_wr_data;
      rf[reg_addr] <= reg_wr_data;
    end
    if (reg_rd_req) begin
      n_rd <= n_rd + 1;
      reg_rd_data <= rf[reg_addr];
    end
    if (frame_done) n_done <= n_done + 1;
    if (frame_err) n_err <= n_err + 1;
    if (reg_wr_en && reg_rd_req) n_both <= n_both + 1;
    if (dut.r_mdio_oe) n_oe <= n_oe + 1;
  end

  // Frame-level rules: preamble gate, ST/OP validity, address match, register effect.
  task automatic model(input int npre, input logic [1:0] st, input logic [1:0] op,
                       input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] wd,
                       output res_t e);
    e = '0;
    if (npre >= PRE) begin
      if (st != 2'b01 || op == 2'b00 || op == 2'b11) e.err = 1;
      else if (phy == PHY) begin
        e.done = 1;
        exp_addr = ra;
        if (op == 2'b01) begin
          e.wr = 1;
          e.wd = wd;
          exp_mem[ra] = wd;
        end else begin
          e.rd = 1;
          e.oe = 1'b1;
          e.rdata = exp_mem[ra];
          e.oe_seq = {2'b01, 16'hFFFF};
        end
      end
    end
    e.addr = exp_addr;
  endtask

  task automatic mbit(input logic drv, input logic v, output logic s_oe, output logic s_v);
    m_oe = drv;
    m_out = v;
    repeat (hp) @(posedge clk);
    #2;
    s_oe = dut.r_mdio_oe;
    s_v = mdio;
    mdc = 1'b1;
    repeat (hp) @(posedge clk);
    #2;
    mdc = 1'b0;
  endtask

  task automatic do_frame(input int npre, input logic [1:0] st, input logic [1:0] op,
                          input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] wd,
                          input int nd, output res_t o, output res_t e);
    int b_wr, b_rd, b_done, b_err, b_oe;
    logic so, sv, rel, post;
    logic [17:0] oe_seq, val_seq;
    b_wr = n_wr; b_rd = n_rd; b_done = n_done; b_err = n_err; b_oe = n_oe;
    rel = (op == 2'b10);
    oe_seq = '0;
    val_seq = '0;
    post = 1'b0;
    model(npre, st, op, phy, ra, wd, e);
    for (int i = 0; i < npre; i++) mbit(1'b1, 1'b1, so, sv);
    for (int i = 1; i >= 0; i--) mbit(1'b1, st[i], so, sv);
    for (int i = 1; i >= 0; i--) mbit(1'b1, op[i], so, sv);
    for (int i = 4; i >= 0; i--) mbit(1'b1, phy[i], so, sv);
    for (int i = 4; i >= 0; i--) mbit(1'b1, ra[i], so, sv);
    mbit(!rel, 1'b1, so, sv); oe_seq[17] = so; val_seq[17] = sv;
    mbit(!rel, 1'b0, so, sv); oe_seq[16] = so; val_seq[16] = sv;
    for (int i = 15; i >= 16 - nd; i--) begin
      mbit(!rel, wd[i], so, sv);
      oe_seq[i] = so;
      val_seq[i] = sv;
    end
    if (nd == 16) begin
      repeat (hp) @(posedge clk);
      #2;
      post = dut.r_mdio_oe;
      m_oe = 1'b1;
      m_out = 1'b1;
      repeat (4) @(posedge clk);
      #2;
    end
    o = '0;
    o.wr = n_wr - b_wr;
    o.rd = n_rd - b_rd;
    o.done = n_done - b_done;
    o.err = n_err - b_err;
    o.oe = (n_oe != b_oe);
    o.post_oe = post;
    o.ta_val = val_seq[16];
    o.oe_seq = oe_seq;
    o.rdata = val_seq[15:0];
    o.wd = cap_wd;
    o.addr = reg_addr;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    checks++; if (reg_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got %h exp %h", reg_addr, 5'd0); end
    checks++; if (reg_wr_data !== 16'd0) begin errors++; $display("FAIL reset_wdata got %h exp %h", reg_wr_data, 16'd0); end
    checks++; if ({reg_wr_en, reg_rd_req, frame_done, frame_err} !== 4'b0) begin errors++; $display("FAIL reset_strobes got %b exp 0000", {reg_wr_en, reg_rd_req, frame_done, frame_err}); end
    checks++; if (dut.r_mdio_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", dut.r_mdio_oe); end
    checks++; if (dut.r_mdio_out !== 1'b1) begin errors++; $display("FAIL reset_out got %b exp 1", dut.r_mdio_out); end
    rst_n = 1'b1;
    exp_addr = '0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_write;
    res_t o, e;
    do_frame(32, 2'b01, 2'b01, 5'b00001, 5'b00100, 16'hA5C3, 16, o, e);
    checks++; if (o.wr !== e.wr) begin errors++; $display("FAIL wr_count got %0d exp %0d", o.wr, e.wr); end
    checks++; if (o.addr !== e.addr) begin errors++; $display("FAIL wr_addr got %h exp %h", o.addr, e.addr); end
    checks++; if (o.wd !== 16'hA5C3) begin errors++; $display("FAIL wr_data got %h exp %h", o.wd, 16'hA5C3); end
    checks++; if (o.done !== e.done) begin errors++; $display("FAIL wr_done got %0d exp %0d", o.done, e.done); end
    checks++; if (o.oe !== 1'b0 || o.rd !== 0) begin errors++; $display("FAIL wr_no_drive got oe %b rd %0d exp 0 0", o.oe, o.rd); end
  endtask

  task automatic test_read;
    res_t o, e;
    do_frame(32, 2'b01, 2'b01, PHY, 5'b00010, 16'h1234, 16, o, e);
    do_frame(32, 2'b01, 2'b10, PHY, 5'b00010, 16'h0000, 16, o, e);
    checks++; if (o.rd !== 1 || o.wr !== 0) begin errors++; $display("FAIL rd_strobes got rd %0d wr %0d exp 1 0", o.rd, o.wr); end
    checks++; if (o.addr !== 5'd2) begin errors++; $display("FAIL rd_addr got %h exp %h", o.addr, 5'd2); end
    checks++; if (o.oe_seq !== e.oe_seq) begin errors++; $display("FAIL rd_oe_seq got %b exp %b", o.oe_seq, e.oe_seq); end
    checks++; if (o.ta_val !== 1'b0) begin errors++; $display("FAIL rd_ta2 got %b exp 0", o.ta_val); end
    checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL rd_data got %h exp %h", o.rdata, e.rdata); end
    checks++; if (o.post_oe !== 1'b0 || o.done !== 1) begin errors++; $display("FAIL rd_end got oe %b done %0d exp 0 1", o.post_oe, o.done); end
  endtask

  task automatic test_skip;
    res_t o, e;
    for (int k = 0; k < 2; k++) begin
      do_frame(32, 2'b01, k ? 2'b01 : 2'b10, 5'b00011, 5'd7, 16'hFFFF, 16, o, e);
      checks++; if (o.wr + o.rd + o.done !== 0) begin errors++; $display("FAIL skip%0d_strobes got %0d exp 0", k, o.wr + o.rd + o.done); end
      checks++; if (o.oe !== 1'b0 || o.addr !== e.addr) begin errors++; $display("FAIL skip%0d_oe_addr got %b %h exp 0 %h", k, o.oe, o.addr, e.addr); end
    end
    do_frame(32, 2'b01, 2'b10, PHY, 5'd4, 16'h0, 16, o, e);
    checks++; if (o.rdata !== e.rdata || o.done !== 1) begin errors++; $display("FAIL skip_after got %h done %0d exp %h 1", o.rdata, o.done, e.rdata); end
  endtask

  task automatic test_preamble_and_errors;
    res_t o, e;
    do_frame(20, 2'b01, 2'b01, PHY, 5'd7, 16'h5555, 16, o, e);
    checks++; if (o.wr + o.done + o.err !== 0) begin errors++; $display("FAIL short_pre got %0d exp 0", o.wr + o.done + o.err); end
    checks++; if (o.addr !== e.addr) begin errors++; $display("FAIL short_pre_addr got %h exp %h", o.addr, e.addr); end
    do_frame(32, 2'b01, 2'b11, PHY, 5'd7, 16'h5555, 16, o, e);
    checks++; if (o.err !== e.err) begin errors++; $display("FAIL bad_op_err got %0d exp %0d", o.err, e.err); end
    checks++; if (o.wr + o.rd + o.done !== 0) begin errors++; $display("FAIL bad_op_strobes got %0d exp 0", o.wr + o.rd + o.done); end
    do_frame(32, 2'b00, 2'b01, PHY, 5'd7, 16'h5555, 16, o, e);
    checks++; if (o.err !== e.err || o.wr !== 0) begin errors++; $display("FAIL bad_st got err %0d wr %0d exp %0d 0", o.err, o.wr, e.err); end
  endtask

  task automatic test_reset_mid_read;
    res_t o, e;
    int b_done;
    do_frame(32, 2'b01, 2'b01, PHY, 5'd9, 16'h5A0F, 16, o, e);
    b_done = n_done;
    do_frame(32, 2'b01, 2'b10, PHY, 5'd9, 16'h0, 5, o, e);
    checks++; if (dut.r_mdio_oe !== 1'b1) begin errors++; $display("FAIL abort_pre_oe got %b exp 1", dut.r_mdio_oe); end
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    checks++; if (dut.r_mdio_oe !== 1'b0) begin errors++; $display("FAIL abort_oe got %b exp 0", dut.r_mdio_oe); end
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    m_oe = 1'b1;
    m_out = 1'b1;
    exp_addr = '0;
    repeat (hp * 4) @(posedge clk);
    #2;
    checks++; if (n_done - b_done !== 0) begin errors++; $display("FAIL abort_done got %0d exp 0", n_done - b_done); end
    checks++; if (reg_addr !== exp_addr) begin errors++; $display("FAIL abort_addr got %h exp %h", reg_addr, exp_addr); end
    do_frame(32, 2'b01, 2'b10, PHY, 5'd9, 16'h0, 16, o, e);
    checks++; if (o.rdata !== e.rdata || o.done !== 1) begin errors++; $display("FAIL abort_reread got %h done %0d exp %h 1", o.rdata, o.done, e.rdata); end
  endtask

  task automatic test_back_to_back;
    res_t o, e;
    logic [4:0] ra;
    ra = 5'($urandom_range(0, 31));
    hp = 12;
    do_frame(32, 2'b01, 2'b01, PHY, ra, 16'hBEEF, 16, o, e);
    do_frame(32, 2'b01, 2'b10, PHY, ra, 16'h0, 16, o, e);
    checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL b2b_read got %h exp %h", o.rdata, e.rdata); end
    checks++; if (o.rdata !== 16'hBEEF) begin errors++; $display("FAIL b2b_loop got %h exp %h", o.rdata, 16'hBEEF); end
    hp = 5;
  endtask

  task automatic test_random;
    res_t o, e;
    logic [1:0] op;
    logic [4:0] phy;
    int sel;
    for (int k = 0; k < 12; k++) begin
      op = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 3);
      phy = (sel < 2) ? PHY : (sel == 2) ? 5'd3 : 5'($urandom_range(0, 31));
      do_frame($urandom_range(32, 36), 2'b01, op, phy, 5'($urandom_range(0, 31)),
               16'($urandom), 16, o, e);
      checks++; if (o.wr !== e.wr || o.rd !== e.rd) begin errors++; $display("FAIL rnd%0d_strobes got %0d %0d exp %0d %0d", k, o.wr, o.rd, e.wr, e.rd); end
      checks++; if (o.done !== e.done || o.err !== e.err) begin errors++; $display("FAIL rnd%0d_done_err got %0d %0d exp %0d %0d", k, o.done, o.err, e.done, e.err); end
      checks++; if (o.addr !== e.addr) begin errors++; $display("FAIL rnd%0d_addr got %h exp %h", k, o.addr, e.addr); end
      checks++; if (o.oe !== e.oe || o.oe_seq !== e.oe_seq || o.post_oe !== 1'b0) begin errors++; $display("FAIL rnd%0d_oe got %b %b %b exp %b %b 0", k, o.oe, o.oe_seq, o.post_oe, e.oe, e.oe_seq); end
      if (e.rd == 1) begin
        checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL rnd%0d_rdata got %h exp %h", k, o.rdata, e.rdata); end
      end
      if (e.wr == 1) begin
        checks++; if (o.wd !== e.wd) begin errors++; $display("FAIL rnd%0d_wdata got %h exp %h", k, o.wd, e.wd); end
      end
    end
    checks++; if (n_both !== 0) begin errors++; $display("FAIL both_strobes got %0d exp 0", n_both); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) exp_mem[i] = '0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    test_reset;
    test_write;
    test_read;
    test_skip;
    test_preamble_and_errors;
    test_reset_mid_read;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
